pingpong_reader: RTL and testbench
==================================

# pingpong_reader

Two-entry ping-pong buffer: the writer side fills alternating banks and the reader side drains them in order over a valid/ready stream. It sits between a producer that has no backpressure-free timing and a consumer that stalls, for example between a datapath register stage and a downstream arbiter. Because banks are updated exclusively, each bank has a single write and a single clear point per cycle. Ordering is strictly first-in-first-out across the two banks.

## Interface
- WIDTH, 32, data width in bits.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous assert, active-low; synchronous deassert is provided upstream.
- clkgate  input  1  enable; when 0, no state changes and both handshakes are suppressed.
- flush  input  1  synchronous clear of both banks and both pointers.
- wr_valid  input  1  writer offers wr_data.
- wr_data  input  WIDTH  write payload.
- wr_ready  output  1  buffer can accept a word this cycle.
- rd_valid  output  1  rd_data holds the oldest buffered word.
- rd_data  output  WIDTH  read payload; forced to 0 when rd_valid=0.
- rd_ready  input  1  reader accepts rd_data.
- count  output  2  number of occupied banks, 0..2.

## Operation
- State:
  - ping_q, pong_q (WIDTH each, data path, no reset).
  - pingFull_q, pongFull_q (1 each).
  - wrSel_q, rdSel_q (1 each; 0=ping, 1=pong).
- Write fire: clkgate & wr_valid & wr_ready.
  - Stores wr_data into the bank selected by wrSel_q.
  - Sets that bank's full flag.
  - Toggles wrSel_q.
- Read fire: clkgate & rd_valid & rd_ready.
  - Clears the full flag of the bank selected by rdSel_q.
  - Toggles rdSel_q.
- wr_ready = clkgate & ~full[wrSel_q] & ~flush.
- rd_valid = clkgate & full[rdSel_q] & ~flush.
- rd_data = rd_valid ? bank[rdSel_q] : 0.
- count = pingFull_q + pongFull_q (2-bit add, no overflow possible).
- Write fire and read fire in the same cycle:
  - Always target different banks, because wrSel_q≠rdSel_q whenever both are enabled with count=1.
  - When count=0, wrSel_q==rdSel_q and rd_valid=0, so they cannot collide.
  - Both updates apply. count is unchanged when exactly one bank is occupied.
- count=2: wr_ready=0. There is no same-cycle pass-through; a read fire frees a bank and wr_ready rises the next cycle.
- count=0: rd_valid=0. There is no bypass; a written word is first visible the cycle after the write.
- Pointer wrap: the 1-bit pointers toggle naturally, ping→pong→ping.
- flush=1 with clkgate=1:
  - Clears both full flags and both pointers to 0.
  - Takes priority over any write or read in that cycle; no handshake fires.
- flush=1 with clkgate=0: ignored.
- clkgate=0: all flags, pointers and banks hold. wr_ready=0, rd_valid=0, rd_data=0.

## Timing
- Reset (rst=0, asynchronous):
  - pingFull_q=0, pongFull_q=0, wrSel_q=0, rdSel_q=0.
  - Therefore count=0, rd_valid=0, rd_data=0, and wr_ready=clkgate.
- Latency: a word written at edge N appears with rd_valid=1 in the cycle after edge N.
- Throughput: one word per cycle sustained when the reader holds rd_ready=1.
- Full buffer: with count=2 and a read fire at edge N, wr_ready=1 in the cycle after edge N.
- All outputs other than registered state are combinational from state plus clkgate/flush. There are no combinational paths from wr_valid or rd_ready to any output.
- Reset asserted mid-transfer: buffered words are discarded immediately, asynchronously. The first post-reset write goes to ping.

## Test plan
- Reset then idle, clkgate=1: count=0, rd_valid=0, rd_data=0, wr_ready=1. After rst rises, writing 0xA5 gives rd_valid=1 and rd_data=0xA5 the next cycle.
- Fill then drain, rd_ready=0:
  - Writes 0x11 then 0x22 → count=2, wr_ready=0; a third wr_valid is not accepted.
  - Raising rd_ready yields 0x11, then 0x22; wr_ready returns 1 the cycle after the first read.
- Streaming, wr_valid=rd_ready=1 continuously with 0..99 → rd_data sequence 0..99 with no gaps after the first cycle. count stays at 1.
- clkgate=0 with count=1 and both valid/ready high → no state change, wr_ready=rd_valid=0, rd_data=0. Restoring clkgate resumes with the same word.
- flush with count=2 and simultaneous wr_valid/rd_ready → no fire that cycle. count=0 afterwards, and the next write lands in ping and is read back first.
- Asynchronous rst pulse mid-cycle with count=1 → rd_valid drops before the next edge and count=0. A subsequent write of 0x5A reads back 0x5A.

Source files
------------

// File: rtl/pingpong_reader_if.sv
// Stream bundle for the ping-pong buffer: writer handshake, reader handshake,
// the clock-gate/flush controls and the occupancy count.
interface pingpong_reader_if #(
    parameter int WIDTH = 32
);
    logic             clkgate;
    logic             flush;
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_ready;
    logic [1:0]       count;

    modport master (
        output clkgate, flush, wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, count
    );

    modport slave (
        input  clkgate, flush, wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, count
    );
endinterface

// File: rtl/pingpong_reader.sv
// Two-bank ping-pong FIFO: writer fills banks alternately, reader drains them
// in the same order. Outputs depend only on state plus clkgate/flush.
module pingpong_reader #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pingpong_reader_if.slave  bus
);
    logic [WIDTH-1:0] r_bank [2];
    logic [1:0]       r_full;
    logic             r_wr_sel;
    logic             r_rd_sel;

    logic             w_enable;
    logic             w_wr_ready;
    logic             w_rd_valid;
    logic             w_wr_fire;
    logic             w_rd_fire;

    // flush is folded into the ready/valid terms, so it blocks both fires.
    assign w_enable   = bus.clkgate & ~bus.flush;
    assign w_wr_ready = w_enable & ~r_full[r_wr_sel];
    assign w_rd_valid = w_enable &  r_full[r_rd_sel];
    assign w_wr_fire  = bus.wr_valid & w_wr_ready;
    assign w_rd_fire  = bus.rd_ready & w_rd_valid;

    assign bus.wr_ready = w_wr_ready;
    assign bus.rd_valid = w_rd_valid;
    assign bus.rd_data  = w_rd_valid ? r_bank[r_rd_sel] : '0;
    assign bus.count    = {1'b0, r_full[0]} + {1'b0, r_full[1]};

    // Data banks carry no reset; their full flags decide whether they are read.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_bank[r_wr_sel] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full   <= 2'b00;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
        end else if (bus.clkgate) begin
            if (bus.flush) begin
                r_full   <= 2'b00;
                r_wr_sel <= 1'b0;
                r_rd_sel <= 1'b0;
            end else begin
                // Simultaneous fires always hit different banks.
                if (w_wr_fire) begin
                    r_full[r_wr_sel] <= 1'b1;
                    r_wr_sel         <= ~r_wr_sel;
                end
                if (w_rd_fire) begin
                    r_full[r_rd_sel] <= 1'b0;
                    r_rd_sel         <= ~r_rd_sel;
                end
            end
        end
    end
endmodule

// File: tb/tb_pingpong_reader.sv
// Bench for pingpong_reader: fixed vector table, a queue-based scoreboard
// checked every cycle, plus hand-written streaming and async-reset sequences.
module tb_pingpong_reader;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    pingpong_reader_if #(.WIDTH(WIDTH)) bus ();

    pingpong_reader #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] sb_q [$];

    typedef struct {
        logic             cg;
        logic             fl;
        logic             wv;
        logic [WIDTH-1:0] wd;
        logic             rr;
        logic             e_wr_ready;
        logic             e_rd_valid;
        logic [WIDTH-1:0] e_rd_data;
        logic [1:0]       e_count;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, sample 1 ns later against the scoreboard,
    // then advance the scoreboard across the rising edge.
    task automatic step(input logic cg, input logic fl, input logic wv, input logic [WIDTH-1:0] wd,
                        input logic rr, output logic a_wr, output logic a_rv,
                        output logic [WIDTH-1:0] a_rd, output logic [1:0] a_cnt);
        logic exp_wr, exp_rv, wfire, rfire;
        logic [WIDTH-1:0] exp_rd;
        @(negedge clk);
        bus.clkgate  = cg;
        bus.flush    = fl;
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        #1;
        a_wr  = bus.wr_ready;
        a_rv  = bus.rd_valid;
        a_rd  = bus.rd_data;
        a_cnt = bus.count;
        exp_wr = cg && !fl && (sb_q.size() < 2);
        exp_rv = cg && !fl && (sb_q.size() > 0);
        exp_rd = exp_rv ? sb_q[0] : '0;
        check("sb_wr_ready", {31'd0, a_wr}, {31'd0, exp_wr});
        check("sb_rd_valid", {31'd0, a_rv}, {31'd0, exp_rv});
        check("sb_rd_data", a_rd, exp_rd);
        check("sb_count", {30'd0, a_cnt}, sb_q.size());
        wfire = exp_wr && wv;
        rfire = exp_rv && rr;
        @(posedge clk);
        if (cg && fl) begin
            sb_q.delete();
        end else begin
            if (rfire) void'(sb_q.pop_front());
            if (wfire) sb_q.push_back(wd);
        end
    endtask

    function automatic vec_t mk(input logic cg, input logic fl, input logic wv, input logic [WIDTH-1:0] wd,
                                input logic rr, input logic ewr, input logic erv,
                                input logic [WIDTH-1:0] erd, input logic [1:0] ecnt);
        vec_t v;
        v.cg = cg; v.fl = fl; v.wv = wv; v.wd = wd; v.rr = rr;
        v.e_wr_ready = ewr; v.e_rd_valid = erv; v.e_rd_data = erd; v.e_count = ecnt;
        return v;
    endfunction

    logic             a_wr, a_rv;
    logic [WIDTH-1:0] a_rd;
    logic [1:0]       a_cnt;

    initial begin
        // Each row: inputs, then outputs expected before that cycle's edge.
        vecs.push_back(mk(1,0,0,32'h00,0, 1,0,32'h00,0)); // idle after reset
        vecs.push_back(mk(1,0,1,32'hA5,0, 1,0,32'h00,0)); // write A5
        vecs.push_back(mk(1,0,0,32'h00,1, 1,1,32'hA5,1)); // visible next cycle, read it
        vecs.push_back(mk(1,0,1,32'h11,0, 1,0,32'h00,0)); // fill: 11
        vecs.push_back(mk(1,0,1,32'h22,0, 1,1,32'h11,1)); // fill: 22
        vecs.push_back(mk(1,0,1,32'h33,0, 0,1,32'h11,2)); // full: 33 refused
        vecs.push_back(mk(1,0,0,32'h00,1, 0,1,32'h11,2)); // drain 11
        vecs.push_back(mk(1,0,0,32'h00,1, 1,1,32'h22,1)); // wr_ready back, drain 22
        vecs.push_back(mk(1,0,0,32'h00,0, 1,0,32'h00,0)); // empty, 33 never stored
        vecs.push_back(mk(1,0,1,32'h44,0, 1,0,32'h00,0)); // write 44
        vecs.push_back(mk(0,0,1,32'h55,1, 0,0,32'h00,1)); // clkgate low: frozen
        vecs.push_back(mk(1,0,0,32'h00,0, 1,1,32'h44,1)); // resumes with 44
        vecs.push_back(mk(1,0,1,32'h66,0, 1,1,32'h44,1)); // write 66 -> full
        vecs.push_back(mk(1,1,1,32'h77,1, 0,0,32'h00,2)); // flush beats both fires
        vecs.push_back(mk(1,0,1,32'h88,0, 1,0,32'h00,0)); // empty, write 88
        vecs.push_back(mk(1,0,1,32'h99,0, 1,1,32'h88,1)); // write 99
        vecs.push_back(mk(1,0,0,32'h00,1, 0,1,32'h88,2)); // 88 first
        vecs.push_back(mk(1,0,0,32'h00,1, 1,1,32'h99,1)); // then 99
        vecs.push_back(mk(1,0,1,32'hAA,0, 1,0,32'h00,0)); // write AA
        vecs.push_back(mk(0,1,0,32'h00,0, 0,0,32'h00,1)); // flush ignored when gated
        vecs.push_back(mk(1,0,0,32'h00,1, 1,1,32'hAA,1)); // AA survived
        vecs.push_back(mk(1,0,0,32'h00,0, 1,0,32'h00,0)); // empty

        bus.clkgate  = 1'b1;
        bus.flush    = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        check("rst_count", {30'd0, bus.count}, 32'd0);
        check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("rst_rd_data", bus.rd_data, 32'd0);
        check("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].cg, vecs[i].fl, vecs[i].wv, vecs[i].wd, vecs[i].rr, a_wr, a_rv, a_rd, a_cnt);
            check($sformatf("vec%0d_wr_ready", i), {31'd0, a_wr}, {31'd0, vecs[i].e_wr_ready});
            check($sformatf("vec%0d_rd_valid", i), {31'd0, a_rv}, {31'd0, vecs[i].e_rd_valid});
            check($sformatf("vec%0d_rd_data", i), a_rd, vecs[i].e_rd_data);
            check($sformatf("vec%0d_count", i), {30'd0, a_cnt}, {30'd0, vecs[i].e_count});
        end

        // Streaming 0..99 with the reader always ready.
        for (int i = 0; i < 100; i++) begin
            step(1, 0, 1, i, 1, a_wr, a_rv, a_rd, a_cnt);
            if (i > 0) begin
                check("stream_rd_valid", {31'd0, a_rv}, 32'd1);
                check("stream_rd_data", a_rd, i - 1);
                check("stream_count", {30'd0, a_cnt}, 32'd1);
            end
        end
        step(1, 0, 0, 0, 1, a_wr, a_rv, a_rd, a_cnt);
        check("stream_last", a_rd, 32'd99);
        step(1, 0, 0, 0, 0, a_wr, a_rv, a_rd, a_cnt);

        // Asynchronous reset pulse between edges with one word buffered.
        step(1, 0, 1, 32'h3C, 0, a_wr, a_rv, a_rd, a_cnt);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        #1;
        check("pre_arst_count", {30'd0, bus.count}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("arst_count", {30'd0, bus.count}, 32'd0);
        sb_q.delete();
        #1;
        rst_n = 1'b1;
        step(1, 0, 1, 32'h5A, 0, a_wr, a_rv, a_rd, a_cnt);
        step(1, 0, 0, 0, 1, a_wr, a_rv, a_rd, a_cnt);
        check("post_arst_data", a_rd, 32'h5A);
        step(1, 0, 0, 0, 0, a_wr, a_rv, a_rd, a_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
